// File: rtl/gshare_predictor.sv
// Direction predictor: 2^HIST_BITS saturating counters indexed by global history,
// optionally XORed with the PC (gshare), with a reset-time table walk and mispredict counter.
module gshare_predictor #(
    parameter int HIST_BITS = 8,
    parameter int CTR_BITS  = 2,
    parameter int PC_BITS   = 32,
    parameter int MODE      = 0,
    parameter int CNT_BITS  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                request,
    input  logic [PC_BITS-1:0]  pc,
    input  logic                result,
    input  logic                taken,
    input  logic [PC_BITS-1:0]  upd_pc,
    input  logic                upd_pred,
    output logic                ready,
    output logic                prediction,
    output logic                pred_valid,
    output logic [CNT_BITS-1:0] mispredicts
);
    localparam int DEPTH = 1 << HIST_BITS;
    localparam logic [CTR_BITS-1:0]  CTR_MAX   = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]  CTR_WEAK  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX   = {CNT_BITS{1'b1}};
    localparam logic [HIST_BITS-1:0] LAST_ADDR = {HIST_BITS{1'b1}};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               state;
    logic [CTR_BITS-1:0]  ctr_table [DEPTH];
    logic [HIST_BITS-1:0] history;
    logic [HIST_BITS-1:0] init_addr;
    logic [HIST_BITS-1:0] pred_idx;
    logic [HIST_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0]  upd_ctr;
    logic [CTR_BITS-1:0]  upd_next;
    logic                 table_we;
    logic [HIST_BITS-1:0] wr_addr;
    logic [CTR_BITS-1:0]  wr_data;
    logic                 unused_pc_bits;

    generate
        if (MODE == 1) begin : g_gshare
            assign pred_idx = history ^ pc[HIST_BITS+1:2];
            assign upd_idx  = history ^ upd_pc[HIST_BITS+1:2];
        end else begin : g_global
            assign pred_idx = history;
            assign upd_idx  = history;
        end
    endgenerate

    assign unused_pc_bits = ^{pc, upd_pc};

    // One write port: the init walk owns it in INIT, resolved branches own it in RUN.
    always_comb begin
        upd_ctr  = ctr_table[upd_idx];
        upd_next = upd_ctr;
        if (taken && (upd_ctr != CTR_MAX)) begin
            upd_next = upd_ctr + CTR_BITS'(1);
        end else if (!taken && (upd_ctr != '0)) begin
            upd_next = upd_ctr - CTR_BITS'(1);
        end

        table_we = 1'b0;
        wr_addr  = upd_idx;
        wr_data  = upd_next;
        if (!rst) begin
            if (state == S_INIT) begin
                table_we = 1'b1;
                wr_addr  = init_addr;
                wr_data  = CTR_WEAK;
            end else if (result) begin
                table_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (table_we) begin
            ctr_table[wr_addr] <= wr_data;
        end
    end

    // Reads below see the pre-update table, so a same-cycle update never leaks into a prediction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_INIT;
            init_addr   <= '0;
            history     <= '0;
            ready       <= 1'b0;
            prediction  <= 1'b0;
            pred_valid  <= 1'b0;
            mispredicts <= '0;
        end else begin
            pred_valid <= 1'b0;
            case (state)
                S_INIT: begin
                    init_addr <= init_addr + HIST_BITS'(1);
                    if (init_addr == LAST_ADDR) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (request) begin
                        prediction <= ctr_table[pred_idx][CTR_BITS-1];
                        pred_valid <= 1'b1;
                    end
                    if (result) begin
                        history <= {history[HIST_BITS-2:0], taken};
                        if ((upd_pred != taken) && (mispredicts != CNT_MAX)) begin
                            mispredicts <= mispredicts + CNT_BITS'(1);
                        end
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor in gshare mode with a 2-bit mispredict counter.
module tb_gshare_predictor;
    localparam int HB    = 8;
    localparam int CB    = 2;
    localparam int PB    = 32;
    localparam int MD    = 1;
    localparam int NB    = 2;
    localparam int DEPTH = 1 << HB;
    localparam int MMAX  = (1 << NB) - 1;
    localparam int CMAX  = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          request;
    logic [PB-1:0] pc;
    logic          result;
    logic          taken;
    logic [PB-1:0] upd_pc;
    logic          upd_pred;
    logic          ready;
    logic          prediction;
    logic          pred_valid;
    logic [NB-1:0] mispredicts;

    always #5 clk = ~clk;

    gshare_predictor #(
        .HIST_BITS(HB), .CTR_BITS(CB), .PC_BITS(PB), .MODE(MD), .CNT_BITS(NB)
    ) dut (
        .clk(clk), .rst(rst), .request(request), .pc(pc), .result(result),
        .taken(taken), .upd_pc(upd_pc), .upd_pred(upd_pred), .ready(ready),
        .prediction(prediction), .pred_valid(pred_valid), .mispredicts(mispredicts)
    );

    typedef struct {
        bit        req;
        bit [31:0] pc;
        bit        res;
        bit        tk;
        bit [31:0] upc;
        bit        upred;
        bit        exp_valid;
        bit        exp_pred;
        int        exp_misp;
    } vec_t;

    typedef struct {
        bit    valid;
        bit    pred;
        int    misp;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of the predictor state
    int mdl_tbl [DEPTH];
    int mdl_hist;
    int mdl_misp;
    bit mdl_pred;

    function automatic vec_t mkv(bit req, bit [31:0] p, bit res, bit tk, bit [31:0] up,
                                 bit upr, bit ev, bit ep, int em);
        vec_t v;
        v.req = req; v.pc = p; v.res = res; v.tk = tk; v.upc = up; v.upred = upr;
        v.exp_valid = ev; v.exp_pred = ep; v.exp_misp = em;
        return v;
    endfunction

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mdl_tbl[i] = (1 << (CB - 1)) - 1;
        mdl_hist = 0;
        mdl_misp = 0;
        mdl_pred = 1'b0;
    endtask

    task automatic modelStep(input vec_t v, output bit ev, output bit ep, output int em);
        int pidx;
        int uidx;
        pidx = mdl_hist ^ int'(v.pc[HB+1:2]);
        uidx = mdl_hist ^ int'(v.upc[HB+1:2]);
        if (v.req) mdl_pred = (mdl_tbl[pidx] >= (1 << (CB - 1)));
        if (v.res) begin
            if (v.tk && mdl_tbl[uidx] < CMAX) mdl_tbl[uidx]++;
            else if (!v.tk && mdl_tbl[uidx] > 0) mdl_tbl[uidx]--;
            mdl_hist = ((mdl_hist << 1) | int'(v.tk)) & (DEPTH - 1);
            if ((v.upred != v.tk) && (mdl_misp < MMAX)) mdl_misp++;
        end
        ev = v.req;
        ep = mdl_pred;
        em = mdl_misp;
    endtask

    task automatic applyStimulus(input vec_t v, input bit use_model, input string name);
        bit   mv;
        bit   mp;
        int   mm;
        exp_t e;
        request  = v.req;
        pc       = v.pc;
        result   = v.res;
        taken    = v.tk;
        upd_pc   = v.upc;
        upd_pred = v.upred;
        modelStep(v, mv, mp, mm);
        e.name = name;
        if (use_model) begin
            e.valid = mv; e.pred = mp; e.misp = mm;
        end else begin
            e.valid = v.exp_valid; e.pred = v.exp_pred; e.misp = v.exp_misp;
        end
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got no expected entry, required one");
            return;
        end
        e = sbq.pop_front();
        checkVal({e.name, "_valid"}, int'(pred_valid), int'(e.valid));
        checkVal({e.name, "_pred"}, int'(prediction), int'(e.pred));
        checkVal({e.name, "_misp"}, int'(mispredicts), e.misp);
    endtask

    task automatic idleInputs();
        request = 1'b0; pc = '0; result = 1'b0; taken = 1'b0; upd_pc = '0; upd_pred = 1'b0;
    endtask

    task automatic resetDut(input string name, input int n);
        idleInputs();
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        checkVal({name, "_ready"}, int'(ready), 0);
        checkVal({name, "_pvalid"}, int'(pred_valid), 0);
        checkVal({name, "_pred"}, int'(prediction), 0);
        checkVal({name, "_misp"}, int'(mispredicts), 0);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic runInit(input string name, input int n);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            checkVal($sformatf("%s_ready%0d", name, c), int'(ready), (c == DEPTH) ? 1 : 0);
            checkVal($sformatf("%s_pvalid%0d", name, c), int'(pred_valid), 0);
        end
    endtask

    vec_t vecs [18];

    initial begin
        // req  pc      res tk upc    upred  valid pred misp
        vecs[0]  = mkv(1, 32'h00, 0, 0, 32'h00, 0, 1, 0, 0);
        vecs[1]  = mkv(0, 32'h00, 1, 0, 32'h00, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 32'h00, 1, 0, 32'h00, 0, 0, 0, 0);
        vecs[3]  = mkv(0, 32'h00, 1, 0, 32'h00, 0, 0, 0, 0);
        vecs[4]  = mkv(1, 32'h00, 0, 0, 32'h00, 0, 1, 0, 0);
        vecs[5]  = mkv(0, 32'h00, 1, 1, 32'h00, 0, 0, 0, 1);
        vecs[6]  = mkv(1, 32'h04, 0, 0, 32'h00, 0, 1, 0, 1);
        vecs[7]  = mkv(0, 32'h00, 1, 1, 32'h04, 1, 0, 0, 1);
        vecs[8]  = mkv(1, 32'h0C, 0, 0, 32'h00, 0, 1, 1, 1);
        vecs[9]  = mkv(0, 32'h00, 1, 1, 32'h10, 0, 0, 1, 2);
        vecs[10] = mkv(1, 32'h00, 0, 0, 32'h00, 0, 1, 1, 2);
        vecs[11] = mkv(1, 32'h04, 0, 0, 32'h00, 0, 1, 0, 2);
        vecs[12] = mkv(1, 32'h08, 1, 1, 32'h08, 1, 1, 0, 2);
        vecs[13] = mkv(1, 32'h28, 0, 0, 32'h00, 0, 1, 1, 2);
        vecs[14] = mkv(0, 32'h00, 1, 0, 32'h00, 1, 0, 1, 3);
        vecs[15] = mkv(0, 32'h00, 1, 0, 32'h00, 1, 0, 1, 3);
        vecs[16] = mkv(0, 32'h00, 1, 1, 32'h00, 1, 0, 1, 3);
        vecs[17] = mkv(0, 32'h00, 0, 0, 32'h00, 0, 0, 1, 3);

        resetDut("reset", 2);

        // Traffic during INIT must be ignored entirely
        request = 1'b1; pc = 32'h0000_0004; result = 1'b1; taken = 1'b1;
        upd_pc = 32'h0000_0008; upd_pred = 1'b0;
        runInit("init", DEPTH);
        checkVal("init_misp", int'(mispredicts), 0);
        idleInputs();

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
            checkOutput();
        end

        for (int i = 0; i < 200; i++) begin
            vec_t v;
            v = mkv($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, 0, 0, 0);
            applyStimulus(v, 1'b1, $sformatf("rand%0d", i));
            checkOutput();
        end

        // Reset after training, then again partway through the walk
        resetDut("run_reset", 1);
        runInit("partial", 100);
        resetDut("mid_reset", 1);
        runInit("reinit", DEPTH);
        idleInputs();

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mkv(1, 32'(i << 2), 0, 0, 32'h0, 0, 1, 0, 0), 1'b0,
                          $sformatf("weak%0d", i));
            checkOutput();
        end

        applyStimulus(mkv(0, 32'h0, 1, 0, 32'h0, 1, 0, 0, 1), 1'b0, "mis1");  checkOutput();
        applyStimulus(mkv(0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 1), 1'b0, "same1"); checkOutput();
        applyStimulus(mkv(0, 32'h0, 1, 0, 32'h0, 1, 0, 0, 2), 1'b0, "mis2");  checkOutput();
        applyStimulus(mkv(0, 32'h0, 1, 0, 32'h0, 1, 0, 0, 3), 1'b0, "mis3");  checkOutput();
        applyStimulus(mkv(0, 32'h0, 1, 0, 32'h0, 1, 0, 0, 3), 1'b0, "mis4");  checkOutput();
        applyStimulus(mkv(0, 32'h0, 1, 0, 32'h0, 1, 0, 0, 3), 1'b0, "mis5");  checkOutput();
        applyStimulus(mkv(0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 3), 1'b0, "same2"); checkOutput();
        applyStimulus(mkv(0, 32'h0, 1, 1, 32'h4, 1, 0, 0, 3), 1'b0, "train"); checkOutput();
        applyStimulus(mkv(1, 32'h0, 0, 0, 32'h0, 0, 1, 1, 3), 1'b0, "probe"); checkOutput();
        idleInputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
